// File: rtl/c_fetch_pkg.sv
// c_fetch_pkg: shared types, constants and helpers for the instruction-fetch stage
package c_fetch_pkg;
  typedef enum logic {BOOT, RUN} fetch_state_e;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] HALF_BYTES = 32'd2;
  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/c_fetch_fifo.sv
// c_fetch_fifo: small response buffer with push/pop/flush and a registered head
module c_fetch_fifo #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   din,
  output logic [31:0]   head,
  output logic [CW-1:0] count
);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk)
    if (reset_i || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = mem[rd];
  // the credit limit upstream must make this unreachable
  assert property (@(posedge clk) disable iff (reset_i) !(push && count == CW'(DEPTH)));
endmodule

// File: rtl/c_fetch_unit.sv
// c_fetch_unit: PC generation, credit-limited word fetch and redirect handling
module c_fetch_unit
  import c_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        stall_i,
  input  logic        pc_half_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;
  fetch_state_e state, state_next;
  logic run;
  logic [31:0] pc, fetch_addr, head;
  logic [CW-1:0] outstanding, outstanding_next, drop_cnt, count;
  logic req_fire, dropping, push, consume, pop;
  always_ff @(posedge clk) state <= reset_i ? BOOT : state_next;
  always_comb state_next = (state == BOOT) ? RUN : state;
  always_comb run = (state == RUN);
  assign imem_req_valid_o = run && !br_taken_i && ({1'b0, outstanding} + {1'b0, count} < SW'(FIFO_DEPTH));
  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  assign dropping = imem_rsp_valid_i && drop_cnt != '0;
  assign push = imem_rsp_valid_i && drop_cnt == '0 && !br_taken_i;
  assign instr_valid_o = run && count != '0 && !br_taken_i;
  assign consume = instr_valid_o && !stall_i;
  // a 16-bit instruction in the lower half keeps the word for the upper half
  assign pop = consume && (!pc_half_i || pc[1]);
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid_i);
  always_ff @(posedge clk)
    if (reset_i) begin
      pc <= RESET_PC;
      fetch_addr <= word_addr(RESET_PC);
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      outstanding <= outstanding_next;
      drop_cnt <= br_taken_i ? outstanding_next : drop_cnt - CW'(dropping);
      pc <= br_taken_i ? {br_target_i[31:1], 1'b0} : consume ? pc + (pc_half_i ? HALF_BYTES : WORD_BYTES) : pc;
      fetch_addr <= br_taken_i ? word_addr(br_target_i) : req_fire ? fetch_addr + WORD_BYTES : fetch_addr;
    end
  c_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_i(reset_i),
    .push(push),
    .pop(pop),
    .flush(br_taken_i),
    .din(imem_rsp_data_i),
    .head(head),
    .count(count)
  );
  assign imem_req_addr_o = fetch_addr;
  assign pc_o = pc;
  assign instr_o = (count != '0) ? head : 32'h0;
endmodule

// File: tb/tb_c_fetch_unit.sv
// tb_c_fetch_unit: directed vector table plus randomized run against a queue-based model
module tb_c_fetch_unit;
  localparam logic [31:0] RPC = 32'h100;
  localparam int DEPTH = 2;
  logic clk = 0, reset_i = 1, br_taken_i = 0, stall_i = 0, pc_half_i = 0;
  logic imem_req_ready_i = 0, imem_rsp_valid_i = 0;
  logic [31:0] br_target_i = 0, imem_rsp_data_i = 0;
  logic imem_req_valid_o, instr_valid_o;
  logic [31:0] imem_req_addr_o, pc_o, instr_o;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  c_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_i(reset_i),
    .br_taken_i(br_taken_i),
    .br_target_i(br_target_i),
    .stall_i(stall_i),
    .pc_half_i(pc_half_i),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i),
    .instr_valid_o(instr_valid_o),
    .pc_o(pc_o),
    .instr_o(instr_o)
  );
  typedef struct {
    logic rst, br;
    logic [31:0] tgt;
    logic stall, half, rdy, rv;
    logic [31:0] rd;
    logic erv;
    logic [31:0] eaddr;
    logic eiv;
    logic [31:0] epc, einstr;
  } vec_t;
  vec_t vt[$];
  logic m_run;
  logic [31:0] m_pc, m_fa;
  logic [32:0] m_infl[$];
  logic [31:0] m_buf[$];
  logic [31:0] mem_q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  task automatic model_reset();
    m_run = 0;
    m_pc = RPC;
    m_fa = RPC;
    m_infl.delete();
    m_buf.delete();
    mem_q.delete();
  endtask
  initial begin
    logic exp_rv, exp_iv, fire_dut, have_rsp;
    logic [31:0] addr_dut;
    logic [32:0] e;
    // fields: rst br tgt stall half rdy rv rd | erv eaddr eiv epc einstr
    vt.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h100, 0});
    vt.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h100, 0, 32'h100, 0});
    vt.push_back('{0, 0, 0, 0, 0, 1, 1, 32'h1111_0000, 1, 32'h104, 0, 32'h100, 0});
    vt.push_back('{0, 0, 0, 1, 0, 1, 1, 32'h2222_0004, 0, 0, 1, 32'h100, 32'h1111_0000});
    vt.push_back('{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 32'h100, 32'h1111_0000});
    vt.push_back('{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 32'h100, 32'h1111_0000});
    vt.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h100, 32'h1111_0000});
    vt.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h108, 1, 32'h104, 32'h2222_0004});
    vt.push_back('{0, 0, 0, 0, 0, 1, 1, 32'h3333_0008, 1, 32'h10C, 0, 32'h108, 0});
    vt.push_back('{0, 0, 0, 0, 1, 0, 1, 32'h4444_000C, 0, 0, 1, 32'h108, 32'h3333_0008});
    vt.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h10A, 32'h3333_0008});
    vt.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h110, 1, 32'h10C, 32'h4444_000C});
    vt.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h114, 0, 32'h110, 0});
    vt.push_back('{0, 1, 32'h2003, 0, 0, 1, 0, 0, 0, 0, 0, 32'h110, 0});
    vt.push_back('{0, 0, 0, 0, 0, 1, 1, 32'hDEAD_0001, 0, 0, 0, 32'h2002, 0});
    vt.push_back('{0, 0, 0, 0, 0, 1, 1, 32'hDEAD_0002, 1, 32'h2000, 0, 32'h2002, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h5555_2000, 1, 32'h2004, 0, 32'h2002, 0});
    vt.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h2004, 1, 32'h2002, 32'h5555_2000});
    vt.push_back('{0, 0, 0, 1, 0, 1, 0, 0, 1, 32'h2004, 0, 32'h2004, 0});
    vt.push_back('{1, 0, 0, 0, 0, 1, 1, 32'hDEAD_0003, 1, 32'h2008, 0, 32'h2004, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h100, 0});
    @(posedge clk);
    @(posedge clk);
    #1;
    foreach (vt[i]) begin
      reset_i = vt[i].rst;
      br_taken_i = vt[i].br;
      br_target_i = vt[i].tgt;
      stall_i = vt[i].stall;
      pc_half_i = vt[i].half;
      imem_req_ready_i = vt[i].rdy;
      imem_rsp_valid_i = vt[i].rv;
      imem_rsp_data_i = vt[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d req_valid", i), 32'(imem_req_valid_o), 32'(vt[i].erv));
      if (vt[i].erv) chk($sformatf("vec%0d req_addr", i), imem_req_addr_o, vt[i].eaddr);
      chk($sformatf("vec%0d instr_valid", i), 32'(instr_valid_o), 32'(vt[i].eiv));
      chk($sformatf("vec%0d pc", i), pc_o, vt[i].epc);
      chk($sformatf("vec%0d instr", i), instr_o, vt[i].einstr);
      @(posedge clk);
      #1;
    end
    reset_i = 1;
    br_taken_i = 0;
    imem_req_ready_i = 0;
    imem_rsp_valid_i = 0;
    @(posedge clk);
    #1;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      reset_i = $urandom_range(0, 299) == 0;
      br_taken_i = $urandom_range(0, 15) == 0;
      br_target_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
      stall_i = $urandom_range(0, 3) == 0;
      pc_half_i = 1'($urandom_range(0, 1));
      imem_req_ready_i = $urandom_range(0, 3) != 0;
      imem_rsp_valid_i = mem_q.size() > 0 && $urandom_range(0, 2) != 0;
      imem_rsp_data_i = imem_rsp_valid_i ? mem_word(mem_q[0]) : 32'h0;
      exp_rv = m_run && !br_taken_i && (m_infl.size() + m_buf.size() < DEPTH);
      exp_iv = m_run && m_buf.size() > 0 && !br_taken_i;
      @(negedge clk);
      chk("rnd req_valid", 32'(imem_req_valid_o), 32'(exp_rv));
      if (exp_rv) chk("rnd req_addr", imem_req_addr_o, m_fa);
      chk("rnd instr_valid", 32'(instr_valid_o), 32'(exp_iv));
      chk("rnd pc", pc_o, m_pc);
      chk("rnd instr", instr_o, m_buf.size() > 0 ? m_buf[0] : 32'h0);
      fire_dut = imem_req_valid_o && imem_req_ready_i;
      addr_dut = imem_req_addr_o;
      if (reset_i) model_reset();
      else begin
        if (imem_rsp_valid_i) void'(mem_q.pop_front());
        if (fire_dut) mem_q.push_back(addr_dut);
        have_rsp = imem_rsp_valid_i && m_infl.size() > 0;
        e = have_rsp ? m_infl.pop_front() : 33'h0;
        if (br_taken_i) begin
          m_buf.delete();
          foreach (m_infl[k]) m_infl[k][32] = 1'b1;
          m_pc = br_target_i & ~32'h1;
          m_fa = br_target_i & ~32'h3;
        end else begin
          if (exp_iv && !stall_i) begin
            if (!pc_half_i || m_pc[1]) void'(m_buf.pop_front());
            m_pc = m_pc + (pc_half_i ? 32'd2 : 32'd4);
          end
          if (have_rsp && !e[32]) m_buf.push_back(mem_word(e[31:0]));
          if (exp_rv && imem_req_ready_i) begin
            m_infl.push_back({1'b0, m_fa});
            m_fa = m_fa + 32'd4;
          end
        end
        m_run = 1;
      end
      @(posedge clk);
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/c_fetch_unit.md
Name: c_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the compressed-decode top.
- Generates the architectural PC, issues word-aligned requests to instruction memory, and buffers returned words in a small FIFO.
- Delivers {pc_o, instr_o} to the decode top and advances the PC by 2 or 4 according to that stage's pc_half feedback.
- Handles branch redirects by flushing the buffer and dropping stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; bit 0 must be 0.
- FIFO_DEPTH, 2, response buffer entries; power of two, at least 2. Also the credit limit on outstanding plus buffered words.

Ports:
- clk  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- br_taken_i  input  1  branch/jump redirect this cycle.
- br_target_i  input  32  redirect PC; bit 0 is ignored and forced to 0.
- stall_i  input  1  downstream hold; a word is consumed only when instr_valid_o=1 and stall_i=0.
- pc_half_i  input  1  current instruction is 16-bit: advance the PC by 2 (else by 4).
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_ready_i  input  1  memory accepts the request.
- imem_req_addr_o  output  32  word address; bits [1:0] are always 00.
- imem_rsp_valid_i  input  1  response valid; responses return in order, one per accepted request.
- imem_rsp_data_i  input  32  response word.
- instr_valid_o  output  1  FIFO head valid.
- pc_o  output  32  current instruction PC.
- instr_o  output  32  FIFO head word; 32'h0 when empty.

Behaviour:
- Reset (one clock, synchronous, active-high):
  - state=BOOT; pc=RESET_PC; fetch_addr={RESET_PC[31:2],2'b00}.
  - FIFO empty; outstanding=0; drop_cnt=0.
  - Outputs: imem_req_valid_o=0, instr_valid_o=0, instr_o=0, pc_o=RESET_PC.
- FSM:
  - BOOT->RUN unconditionally on the next cycle; no requests are issued in BOOT.
  - RUN is terminal until reset.
  - Reset asserted mid-operation discards all in-flight responses. A response arriving in the reset cycle is ignored.
- Request issue: imem_req_valid_o = RUN & !br_taken_i & (outstanding + fifo_count < FIFO_DEPTH).
  - Request fires when valid & ready: outstanding++ and fetch_addr += 4, wrapping at 2^32.
  - Valid may drop without ready only on a redirect or when credits are exhausted; the address is stable while valid is held.
- Response handling:
  - If drop_cnt>0, the response is discarded and drop_cnt--.
  - Otherwise it is pushed to the FIFO.
  - outstanding-- in both cases.
  - Request fire and response in the same cycle leave outstanding unchanged.
- Credit rule: the FIFO can never overflow. A push to a full FIFO is an assertion failure.
- Consume (fire = instr_valid_o & !stall_i):
  - pc += pc_half_i ? 2 : 4.
  - Pop the FIFO head when (!pc_half_i | pc[1]), i.e. when the PC crosses a word boundary.
  - A 16-bit instruction at pc[1]=0 keeps the word for the upper half.
  - instr_valid_o = RUN & fifo_not_empty & !br_taken_i, combinational.
- Redirect (br_taken_i=1), with priority over consume and push:
  - pc={br_target_i[31:1],1'b0}; fetch_addr={br_target_i[31:2],2'b00}.
  - FIFO flushed.
  - drop_cnt_next = outstanding_next, counting a request that fired this cycle (none can fire, since valid is masked) minus a response discarded this cycle.
  - Mid-word target (target[1]=1): the first returned word is used for its upper half.
  - Redirect while drop_cnt>0 accumulates correctly through the same formula.
- Back-to-back redirects in consecutive cycles: only the last target is fetched.
- Latency:
  - A request in cycle N with response in cycle N+k gives instr_valid_o in cycle N+k+1, since the FIFO is registered.
  - First request is issued at cycle 1 after reset deassertion.

Decomposition:
- Package c_fetch_pkg:
  - fetch_state_e {BOOT, RUN}.
  - Constants WORD_BYTES=4, HALF_BYTES=2.
  - Function word_addr(pc) returning {pc[31:2],2'b00}.
- One sub-module, c_fetch_fifo: parameterised depth, push/pop/flush, count, head output, synchronous reset_i.
- Credit, drop counter, PC logic and FSM stay in c_fetch_unit.

Test Plan:
- Reset RESET_PC=0x100, memory ready, 1-cycle response:
  - Requests go to 0x100, 0x104 (then stall at 2 credits).
  - instr_valid_o rises with pc_o=0x100.
- Stream of all 32-bit instructions, stall_i=0: pc_o goes 0x100, 0x104, 0x108, with one pop per fire.
- pc_half_i=1 at pc 0x100, then 0x102:
  - No pop at 0x100; pop at 0x102.
  - pc_o goes 0x100, 0x102, 0x104, and instr_o is unchanged between 0x100 and 0x102.
- Redirect to 0x2002 with 2 requests outstanding:
  - Next 2 responses are dropped and the FIFO is empty.
  - Next request goes to 0x2000.
  - First valid output has pc_o=0x2002.
- stall_i=1 with FIFO full:
  - imem_req_valid_o=0.
  - pc_o and instr_o stay stable.
  - No data is lost on release.
- reset_i asserted with 1 outstanding request and a response arriving in the same cycle:
  - Outputs return to reset values.
  - The response is ignored.
